// File: rtl/rv32i_multicycle_ctrl.sv
// Multi-cycle sequencer for the RV32I core: walks each instruction through
// FETCH, DECODE, EXEC, MEM and WB, and drives the PC/IR/RF strobes, the
// ALU group code and the req/ack memory handshakes around the datapath.
module rv32i_multicycle_ctrl (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ack,
    input  logic        branch_taken,
    output logic [3:0]  alu_op,
    output logic [2:0]  funct3,
    output logic        bit30,
    output logic        ir_we,
    output logic        pc_we,
    output logic [1:0]  pc_sel,
    output logic        rf_we,
    output logic [1:0]  wb_sel,
    output logic        retire,
    output logic        halt,
    output logic        illegal,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        G_LUI    = 4'd0,
        G_AUIPC  = 4'd1,
        G_JAL    = 4'd2,
        G_JALR   = 4'd3,
        G_BRANCH = 4'd4,
        G_LOAD   = 4'd5,
        G_STORE  = 4'd6,
        G_OPIMM  = 4'd7,
        G_OP     = 4'd8,
        G_FENCE  = 4'd9,
        G_SYSTEM = 4'd10
    } grp_t;

    state_t     state_q, state_d;
    grp_t       grp_q, dec_grp;
    logic [6:0] opcode_q;
    logic [2:0] f3_ir_q, funct3_q;
    logic       b30_ir_q, bit30_q, dec_bit30, dec_legal;
    logic       illegal_q;

    // Only opcode, funct3 and bit 30 of the instruction steer the sequencer;
    // the remaining fields go straight from memory to the datapath.
    logic unused_ir_bits;
    assign unused_ir_bits = ^{imem_rdata[31], imem_rdata[29:15], imem_rdata[11:7]};

    // Decode the latched instruction fields into a group code and legality.
    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        dec_grp   = G_LUI;
        dec_legal = 1'b1;
        case (opcode_q)
            7'b0110111: dec_grp = G_LUI;
            7'b0010111: dec_grp = G_AUIPC;
            7'b1101111: dec_grp = G_JAL;
            7'b1100111: dec_grp = G_JALR;
            7'b1100011: dec_grp = G_BRANCH;
            7'b0000011: dec_grp = G_LOAD;
            7'b0100011: dec_grp = G_STORE;
            7'b0010011: dec_grp = G_OPIMM;
            7'b0110011: dec_grp = G_OP;
            7'b0001111: dec_grp = G_FENCE;
            7'b1110011: dec_grp = G_SYSTEM;
            default:    dec_legal = 1'b0;
        endcase
        dec_bit30 = 1'b0;
        if (dec_legal && (dec_grp == G_OP || (dec_grp == G_OPIMM && f3_ir_q == 3'b101)))
            dec_bit30 = b30_ir_q;
    end

    // Next-state logic and Moore strobes; reset forces every output low.
    always_comb begin
        state_d  = state_q;
        imem_req = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        ir_we    = 1'b0;
        pc_we    = 1'b0;
        pc_sel   = 2'b00;
        rf_we    = 1'b0;
        wb_sel   = 2'b00;
        retire   = 1'b0;
        halt     = 1'b0;
        case (state_q)
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_we   = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (!dec_legal || dec_grp == G_SYSTEM) begin
                    state_d = S_HALT;
                end else if (dec_grp == G_FENCE) begin
                    pc_we   = 1'b1;
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (grp_q == G_LOAD || grp_q == G_STORE) begin
                    state_d = S_MEM;
                end else if (grp_q == G_BRANCH) begin
                    pc_we   = 1'b1;
                    pc_sel  = branch_taken ? 2'b01 : 2'b00;
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (grp_q == G_STORE);
                if (dmem_ack) begin
                    if (grp_q == G_STORE) begin
                        pc_we   = 1'b1;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                rf_we   = 1'b1;
                pc_we   = 1'b1;
                retire  = 1'b1;
                state_d = S_FETCH;
                case (grp_q)
                    G_LOAD:         wb_sel = 2'b01;
                    G_JAL, G_JALR:  wb_sel = 2'b10;
                    G_LUI:          wb_sel = 2'b11;
                    default:        wb_sel = 2'b00;
                endcase
                case (grp_q)
                    G_JAL:   pc_sel = 2'b01;
                    G_JALR:  pc_sel = 2'b10;
                    default: pc_sel = 2'b00;
                endcase
            end
            S_HALT:  halt = 1'b1;
            default: state_d = S_FETCH;
        endcase
        alu_op  = grp_q;
        funct3  = funct3_q;
        bit30   = bit30_q;
        illegal = illegal_q;
        state   = state_q;
        if (rst) begin
            state_d  = S_FETCH;
            imem_req = 1'b0;
            dmem_req = 1'b0;
            dmem_we  = 1'b0;
            ir_we    = 1'b0;
            pc_we    = 1'b0;
            pc_sel   = 2'b00;
            rf_we    = 1'b0;
            wb_sel   = 2'b00;
            retire   = 1'b0;
            halt     = 1'b0;
            alu_op   = 4'b0000;
            funct3   = 3'b000;
            bit30    = 1'b0;
            illegal  = 1'b0;
            state    = 3'd0;
        end
    end

    // State register, IR field latch and the ALU-control registers.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            // NOTE: all control registers reset, since downstream decode sees them
            // directly; the datapath IR/PC are owned elsewhere.
            state_q   <= S_FETCH;
            grp_q     <= G_LUI;
            funct3_q  <= 3'b000;
            bit30_q   <= 1'b0;
            illegal_q <= 1'b0;
            opcode_q  <= 7'd0;
            f3_ir_q   <= 3'b000;
            b30_ir_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (ir_we) begin
                opcode_q <= imem_rdata[6:0];
                f3_ir_q  <= imem_rdata[14:12];
                b30_ir_q <= imem_rdata[30];
            end
            if (state_q == S_DECODE) begin
                grp_q    <= dec_grp;
                funct3_q <= f3_ir_q;
                bit30_q  <= dec_bit30;
                if (!dec_legal)
                    illegal_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rv32i_multicycle_ctrl.sv
// Self-checking bench for rv32i_multicycle_ctrl: a per-instruction timeline
// model expands each directed instruction (with its memory wait states) into
// cycle records holding the stimulus and the required outputs.
module tb_rv32i_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req, imem_ack;
    logic [31:0] imem_rdata;
    logic        dmem_req, dmem_we, dmem_ack, branch_taken;
    logic [3:0]  alu_op;
    logic [2:0]  funct3;
    logic        bit30, ir_we, pc_we, rf_we, retire, halt, illegal;
    logic [1:0]  pc_sel, wb_sel;
    logic [2:0]  state;

    always #5 clk = ~clk;

    rv32i_multicycle_ctrl dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
        .branch_taken(branch_taken),
        .alu_op(alu_op), .funct3(funct3), .bit30(bit30),
        .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel), .rf_we(rf_we),
        .wb_sel(wb_sel), .retire(retire), .halt(halt), .illegal(illegal),
        .state(state)
    );

    typedef struct {
        logic        rst, iack, dack, taken;
        logic [31:0] rdata;
        logic        imem_req, dmem_req, dmem_we, ir_we, pc_we, rf_we, retire, halt, illegal;
        logic [1:0]  pc_sel, wb_sel;
        logic [2:0]  state;
        logic [3:0]  alu_op;
        logic [2:0]  funct3;
        logic        bit30, ctl_known;
    } cyc_t;

    cyc_t plan_q[$];
    int   tests = 0, fails = 0;
    int   cur_k = 0;
    logic running = 1'b0;
    int   retire_cnt = 0, rf_cnt = 0;

    // Model view of the ALU-control outputs as they stand after the last DECODE.
    logic [3:0] cur_alu;
    logic [2:0] cur_f3;
    logic       cur_b30, cur_known, cur_illegal;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s (record %0d): got %0h, expected %0h", name, cur_k, act, exp);
        end
    endtask

    // Group code of an instruction from the opcode map; -1 for an illegal opcode.
    function automatic int grp_of(input logic [31:0] ins);
        case (ins[6:0])
            7'b0110111: return 0;
            7'b0010111: return 1;
            7'b1101111: return 2;
            7'b1100111: return 3;
            7'b1100011: return 4;
            7'b0000011: return 5;
            7'b0100011: return 6;
            7'b0010011: return 7;
            7'b0110011: return 8;
            7'b0001111: return 9;
            7'b1110011: return 10;
            default:    return -1;
        endcase
    endfunction

    function automatic cyc_t blank(input logic [2:0] st);
        cyc_t r;
        r = '{default: '0};
        r.state     = st;
        r.alu_op    = cur_alu;
        r.funct3    = cur_f3;
        r.bit30     = cur_b30;
        r.ctl_known = cur_known;
        r.illegal   = cur_illegal;
        return r;
    endfunction

    task automatic plan_reset(input int n, input logic ack_in_first);
        cyc_t r;
        cur_alu = 4'd0; cur_f3 = 3'd0; cur_b30 = 1'b0; cur_known = 1'b1; cur_illegal = 1'b0;
        for (int i = 0; i < n; i++) begin
            r = blank(3'd0);
            r.rst  = 1'b1;
            r.dack = (i == 0) && ack_in_first;
            r.iack = (i == 0) && ack_in_first;
            plan_q.push_back(r);
        end
    endtask

    task automatic plan_halt(input int n);
        cyc_t r;
        for (int i = 0; i < n; i++) begin
            r = blank(3'd5);
            r.halt = 1'b1;
            r.iack = i[0];
            r.dack = ~i[0];
            plan_q.push_back(r);
        end
    endtask

    // Expand one instruction into its cycle records. Stray acks are placed in
    // cycles whose request is low; they must have no effect.
    task automatic plan(input logic [31:0] ins, input int iw, input int dw,
                        input logic taken, input logic abort_mem);
        int   g;
        cyc_t r;
        g = grp_of(ins);
        for (int i = 0; i < iw; i++) begin
            r = blank(3'd0); r.imem_req = 1'b1; r.dack = 1'b1;
            plan_q.push_back(r);
        end
        r = blank(3'd0); r.imem_req = 1'b1; r.iack = 1'b1; r.rdata = ins; r.ir_we = 1'b1;
        plan_q.push_back(r);
        r = blank(3'd1); r.iack = 1'b1; r.rdata = 32'hFFFF_FFFF; r.dack = 1'b1;
        if (g == 9) begin r.pc_we = 1'b1; r.retire = 1'b1; r.pc_sel = 2'b00; end
        plan_q.push_back(r);
        if (g < 0) begin
            cur_known = 1'b0; cur_illegal = 1'b1;
            return;
        end
        cur_known = 1'b1;
        cur_alu   = g[3:0];
        cur_f3    = ins[14:12];
        cur_b30   = (g == 8 || (g == 7 && ins[14:12] == 3'b101)) ? ins[30] : 1'b0;
        if (g == 9 || g == 10) return;
        r = blank(3'd2); r.iack = 1'b1; r.taken = taken;
        if (g == 4) begin
            r.pc_we = 1'b1; r.retire = 1'b1; r.pc_sel = taken ? 2'b01 : 2'b00;
            plan_q.push_back(r);
            return;
        end
        plan_q.push_back(r);
        if (g == 5 || g == 6) begin
            for (int i = 0; i < dw; i++) begin
                r = blank(3'd3); r.dmem_req = 1'b1; r.dmem_we = (g == 6); r.iack = 1'b1;
                plan_q.push_back(r);
            end
            if (abort_mem) return;
            r = blank(3'd3); r.dmem_req = 1'b1; r.dmem_we = (g == 6); r.dack = 1'b1;
            if (g == 6) begin r.pc_we = 1'b1; r.retire = 1'b1; r.pc_sel = 2'b00; end
            plan_q.push_back(r);
            if (g == 6) return;
        end
        r = blank(3'd4); r.iack = 1'b1;
        r.rf_we = 1'b1; r.pc_we = 1'b1; r.retire = 1'b1;
        r.wb_sel = (g == 5) ? 2'b01 : (g == 2 || g == 3) ? 2'b10 : (g == 0) ? 2'b11 : 2'b00;
        r.pc_sel = (g == 2) ? 2'b01 : (g == 3) ? 2'b10 : 2'b00;
        plan_q.push_back(r);
    endtask

    // Compare every DUT output against the current record, mid-cycle.
    always @(negedge clk) begin
        if (running) begin
            cyc_t r;
            r = plan_q[cur_k];
            check("imem_req", imem_req, r.imem_req);
            check("dmem_req", dmem_req, r.dmem_req);
            if (r.dmem_req) check("dmem_we", dmem_we, r.dmem_we);
            check("ir_we", ir_we, r.ir_we);
            check("pc_we", pc_we, r.pc_we);
            if (r.pc_we) check("pc_sel", pc_sel, r.pc_sel);
            check("rf_we", rf_we, r.rf_we);
            if (r.rf_we) check("wb_sel", wb_sel, r.wb_sel);
            check("retire", retire, r.retire);
            check("halt", halt, r.halt);
            check("illegal", illegal, r.illegal);
            check("state", state, r.state);
            if (r.ctl_known) begin
                check("alu_op", alu_op, r.alu_op);
                check("funct3", funct3, r.funct3);
                check("bit30", bit30, r.bit30);
            end
            check("req_overlap", imem_req & dmem_req, 0);
            if (retire) retire_cnt++;
            if (rf_we) rf_cnt++;
        end
    end

    initial begin
        int n0;
        rst = 1'b1; imem_ack = 1'b0; dmem_ack = 1'b0; imem_rdata = '0; branch_taken = 1'b0;

        plan_reset(2, 1'b0);
        n0 = plan_q.size(); plan(32'h002081B3, 0, 0, 1'b0, 1'b0);   // ADD x3,x1,x2
        check("len_add", plan_q.size() - n0, 4);
        check("model_add_grp", grp_of(32'h002081B3), 8);
        plan(32'h4032D293, 0, 0, 1'b0, 1'b0);                        // SRAI x5,x5,3
        check("model_srai_grp", cur_alu, 7);
        check("model_srai_b30", cur_b30, 1);
        plan(32'h40000093, 0, 0, 1'b0, 1'b0);                        // ADDI, IR[30]=1
        check("model_addi_b30", cur_b30, 0);
        n0 = plan_q.size(); plan(32'h0000A103, 2, 3, 1'b0, 1'b0);   // LW x2,0(x1)
        check("len_lw_waits", plan_q.size() - n0, 10);
        n0 = plan_q.size(); plan(32'h00208463, 0, 0, 1'b1, 1'b0);   // BEQ taken
        check("len_beq", plan_q.size() - n0, 3);
        plan(32'h00208463, 1, 0, 1'b0, 1'b0);                        // BEQ not taken
        n0 = plan_q.size(); plan(32'h0000000F, 0, 0, 1'b0, 1'b0);   // FENCE
        check("len_fence", plan_q.size() - n0, 2);
        n0 = plan_q.size(); plan(32'h0020A023, 0, 0, 1'b0, 1'b0);   // SW x2,0(x1)
        check("len_sw", plan_q.size() - n0, 4);
        plan(32'h008000EF, 0, 0, 1'b0, 1'b0);                        // JAL
        plan(32'h00008067, 1, 0, 1'b0, 1'b0);                        // JALR
        plan(32'h123450B7, 0, 0, 1'b0, 1'b0);                        // LUI
        plan(32'h00000097, 0, 0, 1'b0, 1'b0);                        // AUIPC
        plan(32'h40208133, 0, 0, 1'b0, 1'b0);                        // SUB
        plan(32'h00000000, 0, 0, 1'b0, 1'b0);                        // illegal
        plan_halt(20);
        plan_reset(2, 1'b0);
        plan(32'h00000073, 0, 0, 1'b0, 1'b0);                        // ECALL
        plan_halt(5);
        plan_reset(1, 1'b0);
        plan(32'h0020A023, 0, 2, 1'b0, 1'b1);                        // SW aborted in MEM
        plan_reset(2, 1'b1);
        plan(32'h002081B3, 1, 0, 1'b0, 1'b0);                        // ADD after recovery

        @(posedge clk); #1;
        running = 1'b1;
        for (int k = 0; k < plan_q.size(); k++) begin
            cur_k        = k;
            rst          = plan_q[k].rst;
            imem_ack     = plan_q[k].iack;
            imem_rdata   = plan_q[k].rdata;
            dmem_ack     = plan_q[k].dack;
            branch_taken = plan_q[k].taken;
            @(posedge clk); #1;
        end
        running = 1'b0;

        check("retire_total", retire_cnt, 14);
        check("rf_we_total", rf_cnt, 10);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rv32i_multicycle_ctrl.md
# rv32i_multicycle_ctrl

Multi-cycle sequencer for the RV32I core. It steps each instruction through fetch, decode, execute, memory and writeback. It drives the 4-bit ALUOp group code, funct3 and bit30 into the ALU control decoder, and generates the PC, IR, register-file and data-memory strobes around it. Both memory ports use a req/ack handshake so the core tolerates wait states.

## Interface
- No parameters.
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- imem_req  out  1  instruction fetch request
- imem_ack  in  1  fetch complete; imem_rdata valid this cycle
- imem_rdata  in  32  fetched instruction
- dmem_req  out  1  data access request
- dmem_we  out  1  1 = store, 0 = load; valid while dmem_req
- dmem_ack  in  1  data access complete
- branch_taken  in  1  comparator result from datapath, valid in EXEC
- alu_op  out  4  group code: LUI 0000, AUIPC 0001, JAL 0010, JALR 0011, BRANCH 0100, LOAD 0101, STORE 0110, OP-IMM 0111, OP 1000, FENCE 1001, SYSTEM 1010
- funct3  out  3  IR[14:12]
- bit30  out  1  IR[30] for OP; IR[30] for OP-IMM only when funct3=101; else 0
- ir_we  out  1  load IR from imem_rdata
- pc_we  out  1  update PC
- pc_sel  out  2  00 PC+4, 01 PC+imm (taken branch/JAL), 10 (rs1+imm)&~1 (JALR)
- rf_we  out  1  register-file write enable
- wb_sel  out  2  00 ALU result, 01 load data, 10 PC+4, 11 U-immediate
- retire  out  1  one-cycle pulse, instruction completed
- halt  out  1  core stopped
- illegal  out  1  halt cause was an illegal opcode
- state  out  3  FSM state, debug only

## Operation
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5. Reset enters FETCH.
- Opcode map (IR[6:0]) to alu_op: 0110111 LUI, 0010111 AUIPC, 1101111 JAL, 1100111 JALR, 1100011 BRANCH, 0000011 LOAD, 0100011 STORE, 0010011 OP-IMM, 0110011 OP, 0001111 FENCE, 1110011 SYSTEM. Any other value, or IR[1:0]≠11, is illegal.
- FETCH
  - imem_req=1 until imem_ack.
  - In the ack cycle: ir_we=1, next state DECODE.
- DECODE
  - Register alu_op, funct3 and bit30 from IR. They stay stable until the next DECODE.
  - Illegal opcode: next HALT, illegal set to 1.
  - SYSTEM: next HALT, illegal stays 0.
  - FENCE: pc_we=1, pc_sel=00, retire=1, next FETCH.
  - Otherwise: next EXEC.
- EXEC
  - LOAD or STORE: next MEM.
  - BRANCH: pc_we=1; pc_sel=01 if branch_taken, else 00; retire=1; next FETCH.
  - All others: next WB.
- MEM
  - dmem_req=1 until dmem_ack; dmem_we=1 for STORE.
  - On ack, LOAD: next WB.
  - On ack, STORE: pc_we=1, pc_sel=00, retire=1, next FETCH.
- WB
  - rf_we=1, pc_we=1, retire=1, next FETCH.
  - wb_sel: LOAD 01; JAL/JALR 10; LUI 11; others 00.
  - pc_sel: JAL 01; JALR 10; others 00.
- HALT: absorbing state, left only by rst. halt=1, and every strobe and request is 0.
- Strobes (ir_we, pc_we, rf_we, retire) assert in exactly one cycle per instruction.
- Requests
  - imem_req and dmem_req are never high together.
  - Acks are ignored when the matching req is low.
  - A req, once raised, holds until its ack.

## Timing
- Reset values while rst=1: all outputs 0, state=FETCH, alu_op=0000.
  - imem_req rises in the first cycle after rst falls.
- Cycles per instruction with zero-wait memory (ack in the same cycle as req):
  - FENCE 2, BRANCH 3, ALU/LUI/AUIPC/JAL/JALR 4, STORE 4, LOAD 5.
  - Each memory wait cycle adds 1.
- ir_we, pc_we, rf_we, retire, imem_req and dmem_req are Moore outputs of state, qualified by the current-cycle ack where listed. There is no extra register stage.
- alu_op, funct3 and bit30 change only on the clock edge leaving DECODE.
- Reset mid-operation (any state, including MEM with req pending): the next cycle is FETCH with all outputs 0. The requester drops its req and the memory must discard the abandoned access. No retire is issued.
- A simultaneous ack and rst is ignored; reset wins.

## Test plan
- ADD x3,x1,x2 (0x002081B3), zero-wait:
  - alu_op=1000, funct3=000, bit30=0.
  - rf_we and retire both in cycle 4 after fetch start; wb_sel=00, pc_sel=00.
- SRAI x5,x5,3 (0x4032D293), then ADDI with IR[30]=1 (0x40000093):
  - SRAI gives alu_op=0111, funct3=101, bit30=1.
  - The ADDI gives bit30=0.
- LW with imem_ack delayed 2 cycles and dmem_ack delayed 3 cycles:
  - Total 10 cycles; dmem_we=0; wb_sel=01 in WB; imem_req and dmem_req never overlap.
- BEQ, first with branch_taken=1 then with branch_taken=0:
  - pc_sel=01 then 00, with pc_we and retire in cycle 3; rf_we never asserts.
- Illegal opcode (IR=0x00000000), then ECALL (0x00000073):
  - Illegal opcode: HALT with illegal=1; state stays 5 for 20 cycles; rst reenters FETCH.
  - ECALL: halt=1, illegal=0.
- STORE with rst asserted in MEM while dmem_req=1:
  - Next cycle dmem_req=0, state=0, no retire pulse, then a normal fetch resumes.
